// File: rtl/ontest_result_tx_if.sv
// Operand/result pair stream from the unit under test into the result transmitter.
// No ready signal: the source is free-running and loss is reported by the transmitter.
interface ontest_result_tx_if;
   logic        valid;
   logic [31:0] op;
   logic [31:0] result;

   modport master (output valid, op, result);
   modport slave  (input  valid, op, result);
endinterface

// File: rtl/ontest_result_tx.sv
// On-board test result transmitter: buffers {op, result} pairs in a FIFO and sends
// each one as a 9-byte 8N1 UART frame (0xA5, op MSB..LSB, result MSB..LSB).
module ontest_result_tx #(
   parameter int CLK_PER_BIT = 868,
   parameter int FIFO_AW     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   ontest_result_tx_if.slave    pair,
   output logic                 txd,
   output logic                 busy,
   output logic [15:0]          drop_cnt
);

   localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(2 ** FIFO_AW);
   localparam logic [FIFO_AW:0]   COUNT_ONE = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [63:0]        mem [2 ** FIFO_AW];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic [FIFO_AW:0]   count_next;

   logic [1:0]         state_reg;
   logic [1:0]         state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2:0]         bit_idx_reg;
   logic [3:0]         byte_idx_reg;
   logic [7:0]         byte_reg;
   logic [63:0]        frame_reg;
   logic               txd_reg;
   logic               busy_reg;
   logic [15:0]        drop_cnt_reg;

   logic               bit_done;
   logic               pop;
   logic               push;
   logic               drop;
   logic [7:0]         frame_byte [8];

   assign bit_done = (cnt_reg == CNT_LAST);
   assign pop      = (state_reg == IDLE) && (count_reg != '0);
   // A full FIFO still accepts a write on the edge that frees a slot.
   assign push     = pair.valid && ((count_reg != DEPTH_CNT) || pop);
   assign drop     = pair.valid && !push;

   assign txd      = txd_reg;
   assign busy     = busy_reg;
   assign drop_cnt = drop_cnt_reg;

   // Payload bytes after the sync byte, most significant op byte first.
   for (genvar gi = 0; gi < 8; gi++) begin : g_frame_byte
      assign frame_byte[gi] = frame_reg[63 - 8 * gi -: 8];
   end

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + COUNT_ONE;
      end else if (pop && !push) begin
         count_next = count_reg - COUNT_ONE;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (pop) state_next = START;
         START:   if (bit_done) state_next = DATA;
         DATA:    if (bit_done && (bit_idx_reg == 3'd7)) state_next = STOP;
         STOP:    if (bit_done) state_next = (byte_idx_reg < 4'd8) ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr_reg] <= {pair.op, pair.result};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         bit_idx_reg  <= '0;
         byte_idx_reg <= '0;
         byte_reg     <= '0;
         frame_reg    <= '0;
         txd_reg      <= 1'b1;
         busy_reg     <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         busy_reg  <= (state_next != IDLE) || (count_next != '0);
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
         end

         // txd is registered, so each branch sets the level of the bit that starts next.
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  frame_reg    <= mem[rd_ptr_reg];
                  byte_reg     <= 8'hA5;
                  byte_idx_reg <= '0;
                  cnt_reg      <= '0;
                  txd_reg      <= 1'b0;
               end
            end
            START: begin
               if (bit_done) begin
                  cnt_reg     <= '0;
                  bit_idx_reg <= '0;
                  txd_reg     <= byte_reg[0];
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            DATA: begin
               if (bit_done) begin
                  cnt_reg <= '0;
                  if (bit_idx_reg == 3'd7) begin
                     txd_reg <= 1'b1;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     txd_reg     <= byte_reg[bit_idx_reg + 3'd1];
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            STOP: begin
               if (bit_done) begin
                  cnt_reg <= '0;
                  if (byte_idx_reg < 4'd8) begin
                     byte_idx_reg <= byte_idx_reg + 4'd1;
                     byte_reg     <= frame_byte[byte_idx_reg[2:0]];
                     txd_reg      <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            default: begin
               txd_reg <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ontest_result_tx.sv
// Directed bench for ontest_result_tx: decodes txd cycle by cycle against frames
// built from the pairs written, and checks latency, gaps, drops and reset.
module tb_ontest_result_tx;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int FRAME = 90 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        txd;
   logic        busy;
   logic [15:0] drop_cnt;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   ontest_result_tx_if pair_if ();

   ontest_result_tx #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .pair     (pair_if.slave),
      .txd      (txd),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Called at a negedge; the pair is written at the next posedge, numbered wcyc.
   task automatic push_pair(input logic [31:0] o, input logic [31:0] r, output int wcyc);
      pair_if.valid  = 1'b1;
      pair_if.op     = o;
      pair_if.result = r;
      wcyc = cyc + 1;
      @(negedge clk);
      pair_if.valid = 1'b0;
   endtask

   // Waits for the start bit, then compares every cycle of the frame with the
   // expected waveform and also decodes bytes by mid-bit sampling.
   task automatic check_frame(input string name, input logic [63:0] entry, input int limit,
                              output int start_cyc);
      logic [71:0] exp_bytes;
      logic [71:0] got;
      logic [7:0]  cur;
      logic        expb;
      int          w, p, bn, bpos, bad, first_bad;
      exp_bytes = {8'hA5, entry};
      got = '0;
      bad = 0;
      first_bad = -1;
      w = 0;
      while ((txd !== 1'b0) && (w < limit)) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (txd !== 1'b0) begin
         errors++;
         $display("FAIL %s start: txd=%b after %0d cycles, required 0", name, txd, w);
         start_cyc = -1;
         return;
      end
      start_cyc = cyc;
      for (int t = 0; t < FRAME; t++) begin
         if (t > 0) @(negedge clk);
         p    = t / CPB;
         bn   = p / 10;
         bpos = p % 10;
         cur  = exp_bytes[71 - 8 * bn -: 8];
         expb = (bpos == 0) ? 1'b0 : ((bpos == 9) ? 1'b1 : cur[bpos - 1]);
         if (txd !== expb) begin
            if (bad == 0) first_bad = t;
            bad++;
         end
         if ((t % CPB == CPB / 2) && (bpos >= 1) && (bpos <= 8)) begin
            got[64 - 8 * bn + bpos - 1] = txd;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s bits: %0d wrong cycles (first at %0d), required 0", name, bad, first_bad);
      end
      checks++;
      if (got !== exp_bytes) begin
         errors++;
         $display("FAIL %s bytes: got %h, required %h", name, got, exp_bytes);
      end
      $display("frame %s: start cycle %0d, bytes %h", name, start_cyc, got);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      pair_if.valid = 1'b0;
      pair_if.op = '0;
      pair_if.result = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset txd: got %b, required 1", txd); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
      checks++;
      if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset drop_cnt: got %0d, required 0", drop_cnt); end
      reset = 1'b0;
      @(negedge clk);
      $display("reset: txd=%b busy=%b drop_cnt=%0d", txd, busy, drop_cnt);
   endtask

   task automatic test_single;
      int w, s;
      push_pair(32'h40800000, 32'h40000000, w);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single busy after write: got %b, required 1", busy); end
      check_frame("single", {32'h40800000, 32'h40000000}, 50, s);
      checks++;
      if (s - w != 1) begin errors++; $display("FAIL single latency: got %0d cycles, required 1", s - w); end
      @(negedge clk);
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single end: txd=%b busy=%b, required txd=1 busy=0", txd, busy);
      end
   endtask

   task automatic test_back_to_back;
      int w, s1, s2;
      pair_if.valid  = 1'b1;
      pair_if.op     = 32'h3F800000;
      pair_if.result = 32'h3F800000;
      w = cyc + 1;
      @(negedge clk);
      pair_if.op     = 32'h41100000;
      pair_if.result = 32'h40400000;
      @(negedge clk);
      pair_if.valid = 1'b0;
      check_frame("b2b_1", {32'h3F800000, 32'h3F800000}, 50, s1);
      check_frame("b2b_2", {32'h41100000, 32'h40400000}, 50, s2);
      checks++;
      if (s1 - w != 1) begin errors++; $display("FAIL b2b latency: got %0d cycles, required 1", s1 - w); end
      checks++;
      if (s2 - s1 != FRAME + 1) begin
         errors++;
         $display("FAIL b2b period: got %0d cycles, required %0d", s2 - s1, FRAME + 1);
      end
      @(negedge clk);
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b end: txd=%b busy=%b, required txd=1 busy=0", txd, busy);
      end
   endtask

   task automatic test_overflow;
      int  s;
      bit  saw_low;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               pair_if.valid  = 1'b1;
               pair_if.op     = 32'(i);
               pair_if.result = ~32'(i);
               @(negedge clk);
            end
            pair_if.valid = 1'b0;
         end
         begin
            for (int k = 0; k < 5; k++) begin
               check_frame($sformatf("ovf_%0d", k), {32'(k), ~32'(k)}, 50, s);
            end
         end
      join
      checks++;
      if (drop_cnt !== 16'd15) begin errors++; $display("FAIL overflow drop_cnt: got %0d, required 15", drop_cnt); end
      saw_low = 1'b0;
      repeat (400) begin
         @(negedge clk);
         if (txd === 1'b0) saw_low = 1'b1;
      end
      checks++;
      if (saw_low) begin errors++; $display("FAIL overflow extra frame: txd went low, required idle"); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL overflow busy: got %b, required 0", busy); end
   endtask

   task automatic test_full_pop_write;
      logic [15:0] d0;
      logic [31:0] ops [6];
      int          s;
      d0 = drop_cnt;
      for (int k = 0; k < 6; k++) ops[k] = 32'hC0DE0000 + 32'(k);
      fork
         begin
            int w, wx;
            push_pair(ops[0], ~ops[0], w);
            repeat (9) @(negedge clk);
            for (int k = 1; k < 5; k++) push_pair(ops[k], ~ops[k], wx);
            // FIFO now holds 4; the next pop edge is w + 362.
            while (cyc < w + FRAME + 1) @(negedge clk);
            push_pair(ops[5], ~ops[5], wx);
            $display("full pop/write: write at cycle %0d, first write at %0d", wx, w);
         end
         begin
            for (int k = 0; k < 6; k++) begin
               check_frame($sformatf("full_%0d", k), {ops[k], ~ops[k]}, 400, s);
            end
         end
      join
      checks++;
      if (drop_cnt !== d0) begin errors++; $display("FAIL full pop/write drop_cnt: got %0d, required %0d", drop_cnt, d0); end
   endtask

   task automatic test_reset_mid_frame;
      int  w, s, n;
      bit  saw_low;
      push_pair(32'h12345678, 32'h9ABCDEF0, w);
      n = 0;
      while ((txd !== 1'b0) && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL midreset start: txd=%b, required 0", txd); end
      // Offset 133 lies inside the data bits of byte 3.
      repeat (33 * CPB + 1) @(negedge clk);
      reset = 1'b1;
      pair_if.valid  = 1'b1;
      pair_if.op     = 32'hDEADBEEF;
      pair_if.result = 32'hCAFEF00D;
      @(negedge clk);
      reset = 1'b0;
      pair_if.valid = 1'b0;
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL midreset txd: got %b, required 1", txd); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b, required 0", busy); end
      checks++;
      if (drop_cnt !== 16'd0) begin errors++; $display("FAIL midreset drop_cnt: got %0d, required 0", drop_cnt); end
      saw_low = 1'b0;
      repeat (500) begin
         @(negedge clk);
         if (txd === 1'b0 || busy === 1'b1) saw_low = 1'b1;
      end
      checks++;
      if (saw_low) begin errors++; $display("FAIL midreset quiet: activity after reset, required idle"); end
      push_pair(32'h0BADF00D, 32'h600DCAFE, w);
      check_frame("after_reset", {32'h0BADF00D, 32'h600DCAFE}, 50, s);
      checks++;
      if (s - w != 1) begin errors++; $display("FAIL after_reset latency: got %0d cycles, required 1", s - w); end
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 70000; i++) begin
         pair_if.valid  = 1'b1;
         pair_if.op     = 32'(i);
         pair_if.result = 32'(i) ^ 32'hFFFF0000;
         @(negedge clk);
      end
      pair_if.valid = 1'b0;
      checks++;
      if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL saturation drop_cnt: got %h, required ffff", drop_cnt); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL saturation busy: got %b, required 1", busy); end
      $display("saturation: drop_cnt=%h", drop_cnt);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (drop_cnt !== 16'd0 || busy !== 1'b0 || txd !== 1'b1) begin
         errors++;
         $display("FAIL final reset: drop_cnt=%0d busy=%b txd=%b, required 0 0 1", drop_cnt, busy, txd);
      end
   endtask

   initial begin
      reset = 1'b1;
      pair_if.valid = 1'b0;
      pair_if.op = '0;
      pair_if.result = '0;
      @(negedge clk);
      test_reset;
      test_single;
      test_back_to_back;
      test_overflow;
      test_full_pop_write;
      test_reset_mid_frame;
      test_saturation;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ontest_result_tx.md
# ontest_result_tx

On-board test result transmitter: the return path for the on-board operator tests. It accepts the operand/result pair produced by the unit under test (for example `fsqrt` driven by the `make_exp1`/`make_fra1` operand generators), buffers pairs in a small FIFO, and serializes each pair to the host as a fixed 9-byte UART frame. With it, a test run can be checked offline instead of through an ILA.

## Interface

- `CLK_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW entries of 64 bits.

Ports:

- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: `op`/`result` pair is presented this cycle.
- `op` in 32: operand bits fed to the unit under test.
- `result` in 32: result bits from the unit under test.
- `txd` out 1: UART serial output, 8N1, LSB first, idle high.
- `busy` out 1: high while a frame is in flight or the FIFO is non-empty.
- `drop_cnt` out 16: number of pairs discarded due to a full FIFO; saturates at 0xFFFF.

## Operation

- **FIFO write.** Sampled at each rising edge with `valid=1`; entry is {op, result}.
  - Accepted if the FIFO is not full, or if it is full and a pop occurs at the same edge.
  - Otherwise the pair is discarded and `drop_cnt` increments, saturating.
- **Frame format**, 9 bytes in order: 0xA5 (sync), op[31:24], op[23:16], op[15:8], op[7:0], result[31:24], result[23:16], result[15:8], result[7:0].
- **Byte format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly `CLK_PER_BIT` cycles.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `txd=1`. When the FIFO is non-empty, pop at this edge, latch the entry into a 64-bit shift register, set byte index=0, load 0xA5 and go to START.
  - **START:** `txd=0` for `CLK_PER_BIT` cycles, then go to DATA with bit index=0.
  - **DATA:** `txd` = current byte bit[idx]. After `CLK_PER_BIT` cycles, idx++. After bit 7 completes, go to STOP.
  - **STOP:** `txd=1` for `CLK_PER_BIT` cycles. Then:
    - if byte index < 8: byte index++, load the next byte, go to START;
    - else: go to IDLE.
- Back-to-back frames: after the final stop bit the FSM spends exactly one cycle in IDLE (`txd=1`) before the next start bit.
- `busy` = (state≠IDLE) | (FIFO count≠0).
- No input flow control: the source is free-running; loss is reported only through `drop_cnt`.

## Timing

- All outputs are registered.
- Reset values: `txd=1`, `busy=0`, `drop_cnt=0`. FIFO pointers and count = 0; FSM = IDLE.
- Latency, starting from an empty FIFO in IDLE:
  - pair written at edge N;
  - pop at edge N+1; `txd` falls after edge N+1;
  - first data bit begins at edge N+1+`CLK_PER_BIT`.
- Frame duration: 90·`CLK_PER_BIT` cycles. The IDLE cycle between frames makes the per-frame period 90·`CLK_PER_BIT`+1 cycles.
- FIFO boundaries:
  - Empty: no pop; FSM stays in IDLE.
  - Full with simultaneous pop and write: write accepted, count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- Reset mid-frame: at the next edge `txd=1`, FIFO flushed, `drop_cnt=0`, FSM=IDLE. The partial byte is abandoned.
- `valid` asserted during `reset` is ignored.

## Test plan

- **Single frame.** `CLK_PER_BIT`=4; one pair op=0x40800000, result=0x40000000. Required: `txd` decodes to A5 40 80 00 00 40 00 00 00; `txd` falls 1 cycle after the write; frame lasts 360 cycles; `busy` then drops to 0.
- **Back-to-back frames.** Two consecutive `valid` cycles with pairs (0x3F800000, 0x3F800000) and (0x41100000, 0x40400000). Required: two frames in order, separated by exactly 1 idle cycle.
- **Overflow.** `FIFO_AW`=2; 20 consecutive `valid` cycles with op=i, result=~i. Required:
  - 1 pair is popped immediately and 4 are buffered, so 5 frames are sent, for i=0..4;
  - `drop_cnt`=15.
- **Saturation.** Hold `valid`=1 with `txd` busy for 70000 cycles. Required: `drop_cnt` stops at 0xFFFF.
- **Reset mid-frame.** Assert `reset` during the DATA state of byte 3. Required: `txd`=1 from the next edge, `busy`=0, no further frame is sent, and the next write after reset produces a full, correct frame.
- **Simultaneous pop and write on a full FIFO.** Required: the new pair is transmitted later and `drop_cnt` is unchanged.
